sram_bridge_1x3: RTL and testbench
==================================

Name: sram_bridge_1x3

Overview:
- Demultiplexing counterpart of the three-input datapath selectors: routes one CPU-side sram-like master port to one of three sram-like slave ports by address decode.
- The three slaves are 0 = default/memory, 1 = peripheral window, 2 = config window.
- Merges the read-data and acknowledge returns back onto the master port, in request order.
- Sits between the CPU data port and the SoC memory/peripheral controllers.

Parameters:
- S1_BASE, 32'h1faf_0000, base address of slave 1 window
- S1_MASK, 32'hffff_0000, compare mask for slave 1
- S2_BASE, 32'h1fc0_0000, base address of slave 2 window
- S2_MASK, 32'hfff0_0000, compare mask for slave 2
- DEPTH, 4, outstanding-transaction tracking FIFO depth; power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- m_req  in  1  master request valid
- m_wr  in  1  1 = write
- m_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- m_addr  in  32  request address
- m_wdata  in  32  write data
- m_addr_ok  out  1  request accepted this cycle
- m_data_ok  out  1  response (read data or write ack) valid
- m_rdata  out  32  read data, valid with m_data_ok
- s_req  out  3  one-hot per-slave request
- s_wr  out  1  broadcast of m_wr
- s_size  out  2  broadcast of m_size
- s_addr  out  32  broadcast of m_addr
- s_wdata  out  32  broadcast of m_wdata
- s_addr_ok  in  3  per-slave accept
- s_data_ok  in  3  per-slave response
- s_rdata  in  96  slave k read data in bits [32k+31:32k]
- err_unexp  out  1  sticky: data_ok from a slave with no transaction pending at the FIFO head

Behaviour:
- Decode (combinational), with slave 1 taking priority:
  - tgt = 1 if (m_addr & S1_MASK) == S1_BASE;
  - else tgt = 2 if (m_addr & S2_MASK) == S2_BASE;
  - else tgt = 0.
- Tracking FIFO holds the 2-bit tgt of every accepted, not-yet-responded transaction.
  - State: wr_ptr, rd_ptr, count (width log2(DEPTH)+1).
  - Also holds last_tgt = tgt of the most recent push.
- Issue gate: issue_ok = !full && (count == 0 || tgt == last_tgt).
  - Requests to a different slave wait until all outstanding transactions drain. This guarantees in-order return without reorder storage.
- Request routing:
  - s_req[tgt] = m_req && issue_ok; other s_req bits are 0.
  - m_addr_ok = m_req && issue_ok && s_addr_ok[tgt].
  - Push tgt on m_addr_ok.
- Response path:
  - head = FIFO[rd_ptr].
  - m_data_ok = (count != 0) && s_data_ok[head]; m_rdata = s_rdata slice [head].
  - Pop on m_data_ok.
  - When count == 0, m_rdata = 0.
- Slave protocol requirement: data_ok for a transaction arrives no earlier than the cycle after its addr_ok. Therefore a pop always refers to an entry already in the FIFO.
- Simultaneous push and pop in one cycle: both pointers advance, count unchanged.
  - Full with a simultaneous pop still blocks issue: the gate uses registered count, no bypass.
- Wrap-around: pointers are modulo DEPTH.
- err_unexp is set on any cycle where s_data_ok[k] = 1 and not (count != 0 && head == k).
  - Cleared only by reset.
  - The stray response is not forwarded and does not pop.
- Reset (resetn low, asynchronous):
  - count = 0; pointers = 0; last_tgt = 0; err_unexp = 0.
  - While resetn is low, s_req = 0, m_addr_ok = 0, m_data_ok = 0.
  - Outstanding transactions are discarded. Responses arriving after reset release set err_unexp.
- Master must hold its request stable until m_addr_ok. The bridge does not register requests.
- Zero-cycle latency on both paths: the bridge adds no pipeline stage.

Test Plan:
- Read to 0x0000_1000, slave 0 gives addr_ok in cycle 0 and data_ok with rdata = 0xDEADBEEF in cycle 2 → s_req = 3'b001, m_addr_ok in cycle 0, m_data_ok with m_rdata = 0xDEADBEEF in cycle 2, count back to 0.
- Four back-to-back writes to 0x1faf_0010 with slave 1 always accepting and data_ok withheld → four accepts, fifth request stalls (s_req = 0). One data_ok → fifth request accepted the following cycle.
- Read to slave 0 outstanding, then read to 0x1fc0_0004 → slave 2 request held off (s_req = 0) until slave 0 data_ok. Issued in the next cycle; slave 2 rdata = 0x12345678 returns on m_rdata.
- Steady stream to slave 1 with data_ok and addr_ok in the same cycle at count = 2 → count stays 2, pointers wrap past DEPTH without loss. 8 responses are returned in order with the expected data.
- s_data_ok[2] pulsed while the FIFO is empty → m_data_ok = 0, err_unexp = 1 and held; a subsequent legal transaction still completes.
- resetn dropped with 2 outstanding transactions → count = 0 and s_req = 0 immediately. After release, a new read to slave 0 completes normally.

Source files
------------

// File: rtl/sram_bridge_1x3.sv
`default_nettype none
// ============================================================================
// sram_bridge_1x3 : one sram-like master routed to three slaves by address,
//                   responses merged back in request order.
// Revision: 1.0
// ============================================================================
module sram_bridge_1x3 #(
  parameter logic [31:0] S1_BASE = 32'h1faf_0000,
  parameter logic [31:0] S1_MASK = 32'hffff_0000,
  parameter logic [31:0] S2_BASE = 32'h1fc0_0000,
  parameter logic [31:0] S2_MASK = 32'hfff0_0000,
  parameter int          DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_addr_ok,
  output logic        m_data_ok,
  output logic [31:0] m_rdata,
  output logic [2:0]  s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [2:0]  s_addr_ok,
  input  logic [2:0]  s_data_ok,
  input  logic [95:0] s_rdata,
  output logic        err_unexp
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    last_tgt_q, last_tgt_d;
  logic          err_q, err_d;

  logic [1:0]    w_tgt;
  logic [1:0]    w_head;
  logic          w_nonempty;
  logic          w_issue_ok;
  logic          w_tgt_aok;
  logic          w_head_dok;
  logic [31:0]   w_head_data;
  logic [2:0]    w_expect;
  logic          w_push;
  logic          w_pop;

  // Slave 1 window wins when both windows match.
  always_comb begin
    w_tgt = 2'd0;
    if ((m_addr & S1_MASK) == S1_BASE) begin
      w_tgt = 2'd1;
    end else if ((m_addr & S2_MASK) == S2_BASE) begin
      w_tgt = 2'd2;
    end
  end

  assign w_head     = fifo_q[rd_ptr_q];
  assign w_nonempty = (count_q != '0);

  // Switching slaves only once everything has drained keeps returns in order.
  assign w_issue_ok = (count_q != FULL_CNT) && (!w_nonempty || (w_tgt == last_tgt_q));

  always_comb begin
    w_tgt_aok   = s_addr_ok[0];
    w_head_dok  = s_data_ok[0];
    w_head_data = s_rdata[31:0];
    case (w_tgt)
      2'd1:    w_tgt_aok = s_addr_ok[1];
      2'd2:    w_tgt_aok = s_addr_ok[2];
      default: w_tgt_aok = s_addr_ok[0];
    endcase
    case (w_head)
      2'd1: begin
        w_head_dok  = s_data_ok[1];
        w_head_data = s_rdata[63:32];
      end
      2'd2: begin
        w_head_dok  = s_data_ok[2];
        w_head_data = s_rdata[95:64];
      end
      default: begin
        w_head_dok  = s_data_ok[0];
        w_head_data = s_rdata[31:0];
      end
    endcase
  end

  assign s_req     = (resetn && m_req && w_issue_ok) ? (3'b001 << w_tgt) : 3'b000;
  assign m_addr_ok = resetn && m_req && w_issue_ok && w_tgt_aok;
  assign m_data_ok = resetn && w_nonempty && w_head_dok;
  assign m_rdata   = w_nonempty ? w_head_data : 32'h0;

  assign s_wr    = m_wr;
  assign s_size  = m_size;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;

  assign w_push   = m_addr_ok;
  assign w_pop    = m_data_ok;
  assign w_expect = w_nonempty ? (3'b001 << w_head) : 3'b000;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_tgt_d = last_tgt_q;
    err_d      = err_q | (|(s_data_ok & ~w_expect));
    if (w_push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      last_tgt_d = w_tgt;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_tgt_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_tgt_q <= last_tgt_d;
      err_q      <= err_d;
    end
  end

  // Entry contents are only read while count marks them valid, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= w_tgt;
    end
  end

  assign err_unexp = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge_1x3.sv
`default_nettype none
// tb_sram_bridge_1x3 : randomized bench with queue-based slave models and an
// in-order response scoreboard for sram_bridge_1x3.
module tb_sram_bridge_1x3;

  localparam logic [31:0] S1_BASE = 32'h1faf_0000;
  localparam logic [31:0] S1_MASK = 32'hffff_0000;
  localparam logic [31:0] S2_BASE = 32'h1fc0_0000;
  localparam logic [31:0] S2_MASK = 32'hfff0_0000;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m_req = 1'b0;
  logic        m_wr = 1'b0;
  logic [1:0]  m_size = 2'd2;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic [2:0]  s_req;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_addr_ok = 3'b000;
  logic [2:0]  s_data_ok = 3'b000;
  logic [95:0] s_rdata = 96'h0;
  logic        err_unexp;

  sram_bridge_1x3 #(
    .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE), .S2_MASK(S2_MASK),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slv_q[3][$];
  logic [31:0] preset[logic [33:0]];
  int          checks = 0;
  int          errors = 0;
  bit          err_m = 1'b0;
  int          aok_pct[3];
  int          dok_pct[3];
  bit          stray[3];
  bit          thread_done;

  function automatic int ref_tgt(input logic [31:0] a);
    if ((a & S1_MASK) == S1_BASE) return 1;
    if ((a & S2_MASK) == S2_BASE) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] sdata(input int k, input logic [31:0] a);
    logic [33:0] key;
    key = {k[1:0], a};
    if (preset.exists(key)) return preset[key];
    return {a[15:0], a[31:16]} ^ (32'(k + 1) * 32'h1357_9bdf);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 so calls chain back-to-back.
  task automatic issue(input logic [31:0] a, input logic w);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    m_req = 1'b1; m_addr = a; m_wr = w;
    m_size = 2'($urandom_range(2)); m_wdata = $urandom;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (m_addr_ok) ok = 1'b1;
      else begin
        t++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: addr %h never accepted", a);
      m_req = 1'b0;
      sync();
    end else begin
      @(posedge clk);
      exp_q.push_back('{tgt: ref_tgt(a), data: sdata(ref_tgt(a), a)});
      #1 m_req = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || slv_q[0].size() != 0 || slv_q[1].size() != 0 ||
            slv_q[2].size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still expected", exp_q.size());
    end
    sync();
  endtask

  task automatic wait_thread();
    int t;
    t = 0;
    while (!thread_done && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (!thread_done) begin
      checks++;
      errors++;
      $display("FAIL thread_timeout: got busy required done");
    end
    sync();
  endtask

  // Slave models: random accept, in-order responses at least one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        s_addr_ok[k] = (int'($urandom_range(99)) < aok_pct[k]);
        s_data_ok[k] = 1'b0;
        s_rdata[32*k +: 32] = $urandom;
        if (stray[k]) begin
          s_data_ok[k] = 1'b1;
          stray[k] = 1'b0;
        end else if (slv_q[k].size() != 0 && int'($urandom_range(99)) < dok_pct[k]) begin
          s_data_ok[k] = 1'b1;
          s_rdata[32*k +: 32] = sdata(k, slv_q[k].pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (s_req[k] && s_addr_ok[k]) slv_q[k].push_back(s_addr);
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    int         n;
    int         tg;
    bit         iss;
    logic [2:0] esreq;
    logic [2:0] emask;
    logic       eaok;
    logic       edok;
    if (resetn) begin
      n     = exp_q.size();
      tg    = ref_tgt(m_addr);
      iss   = (n < DEPTH) && (n == 0 || exp_q[n-1].tgt == tg);
      esreq = (m_req && iss) ? 3'(1 << tg) : 3'b000;
      eaok  = m_req && iss && s_addr_ok[tg];
      emask = (n != 0) ? 3'(1 << exp_q[0].tgt) : 3'b000;
      edok  = |(s_data_ok & emask);
      chk("s_req", 32'(s_req), 32'(esreq));
      chk("m_addr_ok", 32'(m_addr_ok), 32'(eaok));
      chk("m_data_ok", 32'(m_data_ok), 32'(edok));
      chk("err_unexp", 32'(err_unexp), 32'(err_m));
      if (s_req != 3'b000) chk("s_addr", s_addr, m_addr);
      if (n == 0) begin
        chk("m_rdata_idle", m_rdata, 32'h0);
      end else if (edok) begin
        chk("m_rdata", m_rdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (|(s_data_ok & ~emask)) err_m = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      aok_pct[k] = 100;
      dok_pct[k] = 100;
      stray[k]   = 1'b0;
    end
    preset[{2'd0, 32'h0000_1000}] = 32'hDEAD_BEEF;
    preset[{2'd2, 32'h1fc0_0004}] = 32'h1234_5678;

    // Held in reset with a live request
    m_req = 1'b1; m_addr = 32'h0000_1000;
    #12;
    chk("rst_s_req", 32'(s_req), 32'h0);
    chk("rst_addr_ok", 32'(m_addr_ok), 32'h0);
    chk("rst_data_ok", 32'(m_data_ok), 32'h0);
    chk("rst_err", 32'(err_unexp), 32'h0);
    chk("rst_count", 32'(dut.count_q), 32'h0);
    m_req = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    sync();

    // Single read to slave 0
    issue(32'h0000_1000, 1'b0);
    drain();
    chk("p1_count", 32'(dut.count_q), 32'h0);

    // Fill slave 1 with writes while responses are withheld
    dok_pct[1] = 0;
    thread_done = 1'b0;
    fork
      begin
        repeat (5) issue(32'h1faf_0010, 1'b1);
        thread_done = 1'b1;
      end
    join_none
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("full_stall", {28'h0, m_req, s_req}, {28'h0, 1'b1, 3'b000});
    chk("full_count", 32'(dut.count_q), 32'(DEPTH));
    dok_pct[1] = 100;
    wait_thread();
    drain();

    // Slave 2 request blocked behind outstanding slave 0 read
    dok_pct[0] = 0;
    thread_done = 1'b0;
    fork
      begin
        issue(32'h0000_0100, 1'b0);
        issue(32'h1fc0_0004, 1'b0);
        thread_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("switch_stall", {28'h0, m_req, s_req}, {28'h0, 1'b1, 3'b000});
    dok_pct[0] = 100;
    wait_thread();
    drain();

    // Steady stream to slave 1 with overlapping accepts and responses
    dok_pct[1] = 50;
    for (int i = 0; i < 8; i++) issue(S1_BASE | 32'(i * 4), 1'b0);
    dok_pct[1] = 100;
    drain();
    chk("stream_count", 32'(dut.count_q), 32'h0);

    // Stray response with nothing outstanding
    @(negedge clk);
    stray[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stray_err", 32'(err_unexp), 32'h1);
    sync();
    issue(32'h1fc0_0004, 1'b0);
    drain();
    chk("stray_err_held", 32'(err_unexp), 32'h1);

    // Reset with two transactions outstanding
    dok_pct[0] = 0;
    issue(32'h0000_2000, 1'b0);
    issue(32'h0000_2004, 1'b0);
    aok_pct[0] = 0;
    m_req = 1'b1; m_addr = 32'h0000_2008; m_wr = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_s_req", 32'(s_req), 32'h0);
    chk("arst_addr_ok", 32'(m_addr_ok), 32'h0);
    chk("arst_count", 32'(dut.count_q), 32'h0);
    m_req = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) slv_q[k].delete();
    err_m = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    chk("arst_err", 32'(err_unexp), 32'h0);
    aok_pct[0] = 100;
    dok_pct[0] = 100;
    sync();
    issue(32'h0000_3000, 1'b0);
    drain();

    // Randomized traffic across all three windows
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int          r;
      if (i % 20 == 0) begin
        for (int k = 0; k < 3; k++) begin
          aok_pct[k] = int'($urandom_range(100, 30));
          dok_pct[k] = int'($urandom_range(100, 20));
        end
      end
      r = int'($urandom_range(2));
      a = $urandom;
      if (r == 1) a = S1_BASE | (a & ~S1_MASK);
      else if (r == 2) a = S2_BASE | (a & ~S2_MASK);
      issue(a, 1'($urandom_range(1)));
    end
    drain();
    chk("final_count", 32'(dut.count_q), 32'h0);
    chk("final_err", 32'(err_unexp), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
